// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that hands the transmitter to one frame buffer at a time,
// watches the control/data strobes to judge frame completion, and times out hung frames.
`timescale 1ns/1ps
module tx_frame_arbiter #(
  parameter int          NREQ    = 4,
  parameter int          n       = 11,
  parameter int          width   = 8,
  parameter int          IFG     = 8,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*n-1:0]       req_len,
  input  logic [NREQ*width-1:0]   buf_rdata,
  input  logic                    TX_RDY,
  input  logic                    ctrl_en_in,
  input  logic                    wr_en_in,
  input  logic                    RDen_in,
  input  logic [n-1:0]            RDaddr_in,
  output logic                    tx_start,
  output logic [n-1:0]            data_length,
  output logic [width-1:0]        RDdata_out,
  output logic [NREQ-1:0]         buf_rd_en,
  output logic [n-1:0]            buf_rd_addr,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = n + 1;

  typedef enum logic [2:0] {IDLE, START, WAIT_SOF, WAIT_EOF, GAP} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_idx;
  logic            start_cnt;
  logic [15:0]     to_cnt;
  logic [15:0]     gap_cnt;
  logic [CW-1:0]   wr_cnt;
  logic            ctrl_en_q;

  logic [n-1:0]     len_arr  [NREQ];
  logic [width-1:0] data_arr [NREQ];

  logic [NREQ-1:0] req_masked;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   win_idx;
  logic            win_valid;
  logic [PW-1:0]   rr_next;
  logic [15:0]     to_nxt;
  logic            in_frame;
  logic            timed_out;
  logic            ctrl_rise;
  logic            frame_ok;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign len_arr[k]  = req_len[k*n +: n];
    assign data_arr[k] = buf_rdata[k*width +: width];
  end

  // A requester whose done/err is showing this cycle has not yet seen it, so skip it.
  assign req_masked = req & ~done & ~err;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NREQ);
      if (!win_valid && req_masked[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rr_next   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign to_nxt    = to_cnt + 16'd1;
  assign in_frame  = (state == START) || (state == WAIT_SOF) || (state == WAIT_EOF);
  assign timed_out = in_frame && (to_nxt == TIMEOUT);
  assign ctrl_rise = ctrl_en_in && !ctrl_en_q;
  // A strobe coinciding with the TT edge still belongs to the frame.
  assign frame_ok  = (wr_cnt + CW'(wr_en_in)) == (CW'(data_length) + CW'(4));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      start_cnt   <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      wr_cnt      <= '0;
      ctrl_en_q   <= 1'b0;
      tx_start    <= 1'b0;
      data_length <= '0;
      RDdata_out  <= '0;
      buf_rd_en   <= '0;
      buf_rd_addr <= '0;
      grant       <= '0;
      done        <= '0;
      err         <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below reads the pre-edge values
      // and later assignments in this block override the defaults set here.
      done        <= '0;
      err         <= '0;
      ctrl_en_q   <= ctrl_en_in;
      buf_rd_addr <= RDaddr_in;
      buf_rd_en   <= grant & {NREQ{RDen_in}};
      RDdata_out  <= (grant != '0) ? data_arr[grant_idx] : '0;

      if (timed_out) begin
        err        <= grant;
        grant      <= '0;
        tx_start   <= 1'b0;
        buf_rd_en  <= '0;
        RDdata_out <= '0;
        gap_cnt    <= '0;
        state      <= GAP;
      end else begin
        if (in_frame) to_cnt <= to_nxt;
        case (state)
          IDLE: begin
            if (TX_RDY && win_valid) begin
              rr_ptr <= rr_next;
              if (len_arr[win_idx] == '0) begin
                err <= NREQ'(1) << win_idx;
              end else begin
                grant       <= NREQ'(1) << win_idx;
                grant_idx   <= win_idx;
                data_length <= len_arr[win_idx];
                tx_start    <= 1'b1;
                start_cnt   <= 1'b0;
                to_cnt      <= '0;
                wr_cnt      <= '0;
                state       <= START;
              end
            end
          end
          START: begin
            if (start_cnt) begin
              tx_start <= 1'b0;
              state    <= WAIT_SOF;
            end else begin
              start_cnt <= 1'b1;
            end
          end
          WAIT_SOF: begin
            if (ctrl_rise) state <= WAIT_EOF;
          end
          WAIT_EOF: begin
            if (wr_en_in && (wr_cnt != '1)) wr_cnt <= wr_cnt + 1'b1;
            if (ctrl_rise) begin
              if (frame_ok) done <= grant;
              else          err  <= grant;
              grant      <= '0;
              buf_rd_en  <= '0;
              RDdata_out <= '0;
              gap_cnt    <= '0;
              state      <= GAP;
            end
          end
          GAP: begin
            if (int'(gap_cnt) + 1 >= IFG) state <= IDLE;
            else                          gap_cnt <= gap_cnt + 16'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: a table of single-frame scenarios plus
// hand-written sequences for round-robin order, timeout, async reset and TX_RDY gating.
`timescale 1ns/1ps
module tb_tx_frame_arbiter;

  localparam int          NREQ = 4;
  localparam int          NW   = 11;
  localparam int          DW   = 8;
  localparam int          GAPC = 8;
  localparam logic [15:0] TO   = 16'd100;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*NW-1:0]   req_len;
  logic [NREQ*DW-1:0]   buf_rdata;
  logic                 TX_RDY, ctrl_en_in, wr_en_in, RDen_in;
  logic [NW-1:0]        RDaddr_in;
  logic                 tx_start;
  logic [NW-1:0]        data_length;
  logic [DW-1:0]        RDdata_out;
  logic [NREQ-1:0]      buf_rd_en;
  logic [NW-1:0]        buf_rd_addr;
  logic [NREQ-1:0]      grant, done, err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rd_val [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

  tx_frame_arbiter #(.NREQ(NREQ), .n(NW), .width(DW), .IFG(GAPC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len), .buf_rdata(buf_rdata),
    .TX_RDY(TX_RDY), .ctrl_en_in(ctrl_en_in), .wr_en_in(wr_en_in), .RDen_in(RDen_in),
    .RDaddr_in(RDaddr_in), .tx_start(tx_start), .data_length(data_length),
    .RDdata_out(RDdata_out), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .grant(grant), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int idx_of(input logic [3:0] g);
    for (int k = 0; k < 4; k++) if (g[k]) return k;
    return 0;
  endfunction

  // Transmitter model: waits for the grant, checks the two-cycle start pulse, sends SOF,
  // nwr write strobes (one probe read on the first), then TT. waited = negedges until grant/err.
  task automatic run_frame(input string tag, input logic [3:0] eg, input logic [10:0] el,
                           input int nwr, input logic [3:0] ed, input logic [3:0] ee,
                           output int waited);
    int cyc;
    int ts;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (grant == '0 && err == '0 && cyc < 60);
    waited = cyc;
    check({tag, "_grant"}, grant, eg);
    if (eg == '0) begin
      check({tag, "_err"}, err, ee);
      check({tag, "_no_start"}, tx_start, 0);
      return;
    end
    check({tag, "_len"}, data_length, el);
    ts = 0;
    while (tx_start && ts < 10) begin
      ts++;
      @(negedge clk);
    end
    check({tag, "_start_cycles"}, ts, 2);
    ctrl_en_in = 1'b1;
    @(negedge clk);
    ctrl_en_in = 1'b0;
    for (int i = 0; i < nwr; i++) begin
      wr_en_in  = 1'b1;
      RDen_in   = (i == 0);
      RDaddr_in = 11'h155;
      @(negedge clk);
      if (i == 0) begin
        check({tag, "_rd_en"}, buf_rd_en, eg);
        check({tag, "_rd_addr"}, buf_rd_addr, 11'h155);
        check({tag, "_rd_data"}, RDdata_out, rd_val[idx_of(eg)]);
      end
      wr_en_in = 1'b0;
      RDen_in  = 1'b0;
      @(negedge clk);
    end
    ctrl_en_in = 1'b1;
    @(negedge clk);
    ctrl_en_in = 1'b0;
    check({tag, "_done"}, done, ed);
    check({tag, "_err"}, err, ee);
    check({tag, "_grant_clr"}, grant, 0);
  endtask

  typedef struct {
    logic [3:0]       req;
    logic [3:0][10:0] len;
    int               nwr;
    logic [3:0]       exp_grant;
    logic [10:0]      exp_len;
    logic [3:0]       exp_done;
    logic [3:0]       exp_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int w;
    int cnt;

    // len field order is {len3, len2, len1, len0}; round-robin pointer noted per row.
    vecs[0] = '{4'b0100, {11'd16, 11'd16, 11'd16, 11'd16}, 20, 4'b0100, 11'd16, 4'b0100, 4'b0000}; // rr 0
    vecs[1] = '{4'b0001, {11'd16, 11'd16, 11'd16, 11'd12}, 15, 4'b0001, 11'd12, 4'b0000, 4'b0001}; // rr 3
    vecs[2] = '{4'b0001, {11'd16, 11'd16, 11'd16, 11'd0},   0, 4'b0000, 11'd0,  4'b0000, 4'b0001}; // rr 1
    vecs[3] = '{4'b1010, {11'd7,  11'd16, 11'd5,  11'd16},  9, 4'b0010, 11'd5,  4'b0010, 4'b0000}; // rr 1
    vecs[4] = '{4'b1000, {11'd7,  11'd16, 11'd5,  11'd16}, 11, 4'b1000, 11'd7,  4'b1000, 4'b0000}; // rr 2
    vecs[5] = '{4'b0110, {11'd7,  11'd1,  11'd3,  11'd16},  7, 4'b0010, 11'd3,  4'b0010, 4'b0000}; // rr 0
    vecs[6] = '{4'b0101, {11'd7,  11'd1,  11'd3,  11'd2},   5, 4'b0100, 11'd1,  4'b0100, 4'b0000}; // rr 2
    vecs[7] = '{4'b0011, {11'd7,  11'd1,  11'd3,  11'd2},   6, 4'b0001, 11'd2,  4'b0001, 4'b0000}; // rr 3
    vecs[8] = '{4'b1001, {11'd1,  11'd1,  11'd3,  11'd2},   4, 4'b1000, 11'd1,  4'b0000, 4'b1000}; // rr 1

    reset      = 1'b1;
    req        = '0;
    req_len    = '0;
    buf_rdata  = {rd_val[3], rd_val[2], rd_val[1], rd_val[0]};
    TX_RDY     = 1'b1;
    ctrl_en_in = 1'b0;
    wr_en_in   = 1'b0;
    RDen_in    = 1'b0;
    RDaddr_in  = '0;

    repeat (2) @(negedge clk);
    check("reset_grant", grant, 0);
    check("reset_tx_start", tx_start, 0);
    check("reset_len", data_length, 0);
    check("reset_done_err", {done, err}, 0);
    check("reset_rd", {buf_rd_en, RDdata_out}, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      req     = vecs[i].req;
      req_len = vecs[i].len;
      run_frame($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_len, vecs[i].nwr,
                vecs[i].exp_done, vecs[i].exp_err, w);
      req = '0;
    end

    // All four requesting continuously: order 0,1,2,3,0; grant low for IFG gap cycles + 1 IDLE.
    req     = 4'b1111;
    req_len = {4{11'd4}};
    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("rr%0d", i), 4'b0001 << (i % 4), 11'd4, 8, 4'b0001 << (i % 4), 4'b0000, w);
      check($sformatf("rr%0d_gap", i), w, GAPC + 1);
    end
    req = '0;

    // Transmitter never answers: abort exactly TO cycles after the grant appears.
    req     = 4'b0100;
    req_len = {4{11'd10}};
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (grant == '0 && cnt < 60);
    check("to_grant", grant, 4'b0100);
    cnt = 0;
    while (err == '0 && cnt < 4 * int'(TO)) begin
      @(negedge clk);
      cnt++;
    end
    check("to_cycles", cnt, int'(TO));
    check("to_err", err, 4'b0100);
    check("to_grant_clr", grant, 0);
    check("to_no_done", done, 0);
    check("to_tx_start", tx_start, 0);
    req = 4'b0001;
    run_frame("after_to", 4'b0001, 11'd10, 14, 4'b0001, 4'b0000, w);
    check("after_to_gap", w, GAPC + 1);
    req = '0;

    // Reset in WAIT_EOF clears outputs immediately; arbitration then restarts at requester 0.
    req     = 4'b1100;
    req_len = {4{11'd6}};
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (grant == '0 && cnt < 60);
    check("rst_pre_grant", grant, 4'b0100);
    repeat (3) @(negedge clk);
    ctrl_en_in = 1'b1;
    @(negedge clk);
    ctrl_en_in = 1'b0;
    wr_en_in = 1'b1;
    RDen_in  = 1'b1;
    @(negedge clk);
    wr_en_in = 1'b0;
    check("rst_pre_rd_en", buf_rd_en, 4'b0100);
    #2 reset = 1'b1;
    #1;
    check("rst_async_grant", grant, 0);
    check("rst_async_len", data_length, 0);
    check("rst_async_rd", {buf_rd_en, RDdata_out}, 0);
    check("rst_async_misc", {tx_start, done, err}, 0);
    RDen_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_frame("rst_resume", 4'b0100, 11'd6, 10, 4'b0100, 4'b0000, w);
    check("rst_first_arb", w, 1);
    req = '0;

    // TX_RDY low holds off arbitration; the grant follows one edge after it rises.
    TX_RDY  = 1'b0;
    req     = 4'b0010;
    req_len = {4{11'd3}};
    repeat (12) @(negedge clk);
    check("txrdy_hold", {grant, tx_start}, 0);
    TX_RDY = 1'b1;
    run_frame("txrdy", 4'b0010, 11'd3, 7, 4'b0010, 4'b0000, w);
    check("txrdy_latency", w, 1);
    req = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
